// File: rtl/cdc_hs_pkg.sv
// Shared types and default constants for the 4-phase CDC handshake transmitter.
package cdc_hs_pkg;

   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ_HI = 2'd1,
      ST_REQ_LO = 2'd2
   } hs_state_e;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchronizer that brings the remote acknowledge into the local clock domain.
module ack_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES:0] w_chain;

   assign w_chain[0] = i_async;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic r_q;
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) r_q <= 1'b0;
         else        r_q <= w_chain[gi];
      end
      assign w_chain[gi+1] = r_q;
   end

   assign o_sync = w_chain[STAGES];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack handshake carrying one payload word per transfer.
// Optional watchdog with sticky timeout_err is built only when CDC_HS_TX_TIMEOUT_EN is defined.
module cdc_hs_tx
   import cdc_hs_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  tx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_ready,
   output logic                  tx_done,
   output logic                  req_out,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  ack_in,
   output logic                  timeout_err
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("cdc_hs_tx: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES at least 1");
   end

   hs_state_e             r_state, w_state_next;
   logic                  r_req, w_req_next;
   logic                  r_done, w_done_next;
   logic [DATA_WIDTH-1:0] r_data, w_data_next;
   logic                  w_ack_s;
   logic                  w_ready;

   ack_sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_async (ack_in),
      .o_sync  (w_ack_s)
   );

   // A stale ack still high from a previous transfer blocks new accepts.
   assign w_ready = (r_state == ST_IDLE) && !w_ack_s;

   always_comb begin
      w_state_next = r_state;
      w_req_next   = r_req;
      w_data_next  = r_data;
      w_done_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (tx_valid && w_ready) begin
               w_state_next = ST_REQ_HI;
               w_req_next   = 1'b1;
               w_data_next  = tx_data;
            end
         end
         ST_REQ_HI: begin
            if (w_ack_s) begin
               w_state_next = ST_REQ_LO;
               w_req_next   = 1'b0;
            end
         end
         ST_REQ_LO: begin
            if (!w_ack_s) begin
               w_state_next = ST_IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_req_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
         r_req   <= 1'b0;
         r_done  <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_next;
         r_req   <= w_req_next;
         r_done  <= w_done_next;
         r_data  <= w_data_next;
      end
   end

   assign tx_ready = w_ready;
   assign tx_done  = r_done;
   assign req_out  = r_req;
   assign data_out = r_data;

`ifdef CDC_HS_TX_TIMEOUT_EN
   localparam int             CW       = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  WD_LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] r_wd_cnt, w_wd_cnt_next;
   logic          r_timeout_err;

   // Count saturates at the limit so a hung handshake cannot wrap back to zero.
   always_comb begin
      w_wd_cnt_next = r_wd_cnt;
      if (w_state_next != r_state)
         w_wd_cnt_next = '0;
      else if (r_state != ST_IDLE && r_wd_cnt != WD_LIMIT)
         w_wd_cnt_next = r_wd_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_wd_cnt <= w_wd_cnt_next;
         if (r_state != ST_IDLE && w_wd_cnt_next == WD_LIMIT)
            r_timeout_err <= 1'b1;
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Scoreboard bench for cdc_hs_tx: directed handshake scenarios followed by randomized traffic
// against a remote-side responder with random ack delays.
module tb_cdc_hs_tx;
   import cdc_hs_pkg::*;

   localparam int DW         = 8;
   localparam int SYNC       = 2;
   localparam int TB_TIMEOUT = 10;

   logic          clk      = 1'b0;
   logic          n_rst    = 1'b0;
   logic          tx_valid = 1'b0;
   logic [DW-1:0] tx_data  = '0;
   logic          ack_in   = 1'b0;
   logic          tx_ready, tx_done, req_out, timeout_err;
   logic [DW-1:0] data_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cdc_hs_tx #(
      .DATA_WIDTH     (DW),
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .req_out     (req_out),
      .data_out    (data_out),
      .ack_in      (ack_in),
      .timeout_err (timeout_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: ack as seen by the local domain is ack_in delayed by SYNC sampling edges.
   logic [SYNC-1:0] ack_hist;
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) ack_hist <= '0;
      else        ack_hist <= {ack_hist[SYNC-2:0], ack_in};
   end

   // Remote side: raise ack, expect req to fall SYNC+1 edges later; drop ack, expect done SYNC+1 later.
   task automatic remote_ack(input int d_hi, input int d_lo);
      int n;
      repeat (d_hi) @(posedge clk);
      @(posedge clk); #1 ack_in = 1'b1;
      n = 0;
      do begin @(posedge clk); n++; @(negedge clk); end while (req_out && n < 20);
      check("req_fall_latency", n, SYNC + 1);
      repeat (d_lo) @(posedge clk);
      @(posedge clk); #1 ack_in = 1'b0;
      n = 0;
      do begin @(posedge clk); n++; @(negedge clk); end while (!tx_done && n < 20);
      check("done_latency", n, SYNC + 1);
   endtask

   // Scoreboard: accepted words are queued; popped when req_out rises.
   logic [DW-1:0] exp_q[$];
   int            outstanding = 0;
   logic [DW-1:0] exp_dout    = '0;
   int            n_xfer      = 0;

   initial begin
      logic acc_prev, req_prev, done_prev, acc_now;
      acc_prev = 1'b0; req_prev = 1'b0; done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            exp_q.delete();
            outstanding = 0;
            exp_dout    = '0;
            acc_prev    = 1'b0;
            req_prev    = 1'b0;
            done_prev   = 1'b0;
         end else begin
            if (tx_done) begin
               check("done_one_cycle", done_prev, 1'b0);
               check("done_has_xfer", outstanding > 0, 1'b1);
               if (outstanding > 0) outstanding--;
            end
            check("ready_model", tx_ready, (outstanding == 0) && !ack_hist[SYNC-1]);
            if ((req_out && !req_prev) || acc_prev) begin
               check("req_rise", req_out && !req_prev, acc_prev);
               check("sb_nonempty", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) begin
                  exp_dout = exp_q.pop_front();
                  check("sb_data", data_out, exp_dout);
                  n_xfer++;
                  $display("xfer %0d: data_out=%02h expected=%02h", n_xfer, data_out, exp_dout);
               end
            end else begin
               check("dout_hold", data_out, exp_dout);
            end
`ifndef CDC_HS_TX_TIMEOUT_EN
            check("timeout_tied_low", timeout_err, 1'b0);
`endif
            acc_now = tx_valid && tx_ready;
            if (acc_now) begin
               exp_q.push_back(tx_data);
               outstanding++;
            end
            acc_prev  = acc_now;
            req_prev  = req_out;
            done_prev = tx_done;
         end
      end
   end

   logic resp_en   = 1'b0;
   logic resp_busy = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (resp_en && n_rst && req_out) begin
            resp_busy = 1'b1;
            remote_ack($urandom_range(0, 3), $urandom_range(0, 3));
            resp_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", req_out, 1'b0);
      check("rst_data", data_out, 8'h00);
      check("rst_done", tx_done, 1'b0);
      check("rst_timeout", timeout_err, 1'b0);
      n_rst = 1'b1;

      // Single accept of A5
      @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'hA5;
      @(negedge clk); check("a5_ready", tx_ready, 1'b1);
      @(posedge clk); #1 tx_valid = 1'b0;
      check("a5_req", req_out, 1'b1);
      check("a5_data", data_out, 8'hA5);
      remote_ack(0, 1);
      @(negedge clk); check("a5_done_pulse_end", tx_done, 1'b0);

      // Back-to-back: 11 then 22 with tx_valid held high
      @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h11;
      @(posedge clk); #1
      check("b2b_req1", req_out, 1'b1);
      check("b2b_data1", data_out, 8'h11);
      tx_data = 8'h22;
      remote_ack(1, 2);
      check("b2b_ready_in_done", tx_ready, 1'b1);
      @(posedge clk); #1
      check("b2b_req2", req_out, 1'b1);
      check("b2b_data2", data_out, 8'h22);
      tx_valid = 1'b0;
      remote_ack(0, 0);

      // Stale ack held high across reset release
      @(posedge clk); #1 n_rst = 1'b0; ack_in = 1'b1;
      repeat (2) @(posedge clk); #1 n_rst = 1'b1;
      repeat (3) @(posedge clk); #1 check("stale_ready", tx_ready, 1'b0);
      tx_valid = 1'b1; tx_data = 8'h5A;
      repeat (4) @(posedge clk); #1 check("stale_no_req", req_out, 1'b0);
      ack_in = 1'b0;
      n = 0;
      do begin @(posedge clk); n++; #1; end while (!tx_ready && n < 20);
      check("stale_ready_latency", n, SYNC);
      @(posedge clk); #1
      check("stale_req", req_out, 1'b1);
      check("stale_data", data_out, 8'h5A);
      tx_valid = 1'b0;
      remote_ack(0, 0);

      // Reset while in REQ_HI
      @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h7E;
      @(posedge clk); #1 tx_valid = 1'b0;
      check("mid_req", req_out, 1'b1);
      @(posedge clk); #2 n_rst = 1'b0;
      #1;
      check("mid_rst_req", req_out, 1'b0);
      check("mid_rst_data", data_out, 8'h00);
      check("mid_rst_done", tx_done, 1'b0);
      repeat (2) @(posedge clk); #1 n_rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("mid_no_done", tx_done, 1'b0);
      end

      // Randomized traffic with randomized remote response times
      resp_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1
         tx_valid = 1'($urandom_range(0, 1));
         tx_data  = DW'($urandom);
      end
      tx_valid = 1'b0;
      n = 0;
      while ((outstanding != 0 || resp_busy || req_out || ack_in) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_complete", n < 500, 1'b1);
      resp_en = 1'b0;

`ifdef CDC_HS_TX_TIMEOUT_EN
      // Ack never returned: watchdog fires after TB_TIMEOUT cycles in REQ_HI
      @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h3C;
      @(posedge clk); #1 tx_valid = 1'b0;
      for (int k = 1; k <= TB_TIMEOUT; k++) begin
         @(posedge clk); #1
         check("wd_flag", timeout_err, k >= TB_TIMEOUT);
      end
      check("wd_req_held", req_out, 1'b1);
      @(posedge clk); #1 n_rst = 1'b0;
      #1 check("wd_rst_clear", timeout_err, 1'b0);
      @(posedge clk); #1 n_rst = 1'b1;
`endif

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
